// File: rtl/axis_rate_limiter_pkg.sv
// Shared definitions for the axis_* stream blocks: clog2 constant function,
// reset/valid idle levels, and the token-bucket update operation type.
package axis_rate_limiter_pkg;

   // Level of the synchronous reset input when reset is asserted.
   localparam logic RST_ACTIVE = 1'b1;
   // Level of a valid output while no beat is held.
   localparam logic VALID_IDLE = 1'b0;

   // What happens to the token count in a given cycle.
   typedef enum logic [1:0] {
      TOK_HOLD  = 2'd0,
      TOK_EARN  = 2'd1,
      TOK_SPEND = 2'd2
   } tok_op_e;

   // Number of bits needed to encode value-1; callers pass BURST+1 to size a counter 0..BURST.
   function automatic int clog2(input int value);
      int result;
      int remain;
      result = 0;
      remain = value - 1;
      while (remain > 0) begin
         result = result + 1;
         remain = remain >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/axis_pipe_reg.sv
// One-entry valid/ready register slice. The enable input gates acceptance so an
// outer block can throttle the stream without touching the data path.
module axis_pipe_reg
   import axis_rate_limiter_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] idata,
   input  logic             ivalid,
   output logic             iready,
   output logic [WIDTH-1:0] odata,
   output logic             ovalid,
   input  logic             oready,
   output logic             accept
);

   // The slot can take a new beat when allowed and either empty or draining this cycle.
   assign iready = enable && (!ovalid || oready);
   assign accept = ivalid && iready;

   // Output stage: capture on accept, drop valid once the sink takes the beat.
   always_ff @(posedge clock) begin
      if (reset == RST_ACTIVE) begin
         ovalid <= VALID_IDLE;
         odata  <= '0;
      end else if (accept) begin
         ovalid <= 1'b1;
         odata  <= idata;
      end else if (ovalid && oready) begin
         ovalid <= VALID_IDLE;
      end
   end

endmodule

// File: rtl/axis_rate_limiter.sv
// Token-bucket rate limiter for an AXI-stream. A down-counting tick timer earns
// one token per active period, up to BURST banked tokens; each accepted beat
// spends one. The period is runtime-loadable through period/period_load.
// Optional stall statistics: define AXIS_RATE_LIMITER_STATS_EN to build the
// stall_count counter; otherwise stall_count is tied to zero.
module axis_rate_limiter
   import axis_rate_limiter_pkg::*;
#(
   parameter int          WIDTH          = 8,
   parameter int          PERIOD_WIDTH   = 32,
   parameter int unsigned DEFAULT_PERIOD = 133000000,
   parameter int          BURST          = 1
)(
   input  logic                            clock,
   input  logic                            reset,
   input  logic [PERIOD_WIDTH-1:0]         period,
   input  logic                            period_load,
   input  logic [WIDTH-1:0]                idata,
   input  logic                            ivalid,
   output logic                            iready,
   output logic [WIDTH-1:0]                odata,
   output logic                            ovalid,
   input  logic                            oready,
   output logic [clog2(BURST+1)-1:0]       tokens,
   output logic [31:0]                     stall_count
);

   localparam int TW = clog2(BURST + 1);
   localparam logic [TW-1:0] TOK_ONE  = TW'(1);
   localparam logic [TW-1:0] TOK_FULL = TW'(BURST);
   localparam logic [PERIOD_WIDTH-1:0] P_ONE = PERIOD_WIDTH'(1);
   localparam logic [PERIOD_WIDTH-1:0] DEFAULT_P = PERIOD_WIDTH'(DEFAULT_PERIOD);
   // A period of 0 behaves as 1, so its reload value is 0 as well.
   localparam logic [PERIOD_WIDTH-1:0] DEFAULT_RELOAD =
      (DEFAULT_PERIOD == 0) ? '0 : PERIOD_WIDTH'(DEFAULT_PERIOD - 1);

   logic [PERIOD_WIDTH-1:0] active_period;
   logic [PERIOD_WIDTH-1:0] tick_cnt;
   logic [PERIOD_WIDTH-1:0] reload_val;
   logic [PERIOD_WIDTH-1:0] load_val;
   logic                    tick;
   logic                    accept;
   logic                    have_token;
   tok_op_e                 tok_op;
   logic [TW-1:0]           tokens_next;

   assign reload_val = (active_period == '0) ? '0 : active_period - P_ONE;
   assign load_val   = (period == '0) ? '0 : period - P_ONE;
   // A period load restarts the timer, so it suppresses a tick that would land in the same cycle.
   assign tick       = !period_load && (tick_cnt == '0);
   assign have_token = (tokens != '0);

   // Tick timer: down-count to zero, reload from the active period, restart on load.
   always_ff @(posedge clock) begin
      if (reset == RST_ACTIVE) begin
         active_period <= DEFAULT_P;
         tick_cnt      <= DEFAULT_RELOAD;
      end else if (period_load) begin
         active_period <= period;
         tick_cnt      <= load_val;
      end else if (tick_cnt == '0) begin
         tick_cnt      <= reload_val;
      end else begin
         tick_cnt      <= tick_cnt - P_ONE;
      end
   end

   // Token update: earning and spending in the same cycle cancel, so a tick is never lost while full.
   always_comb begin
      tok_op      = TOK_HOLD;
      tokens_next = tokens;
      if (tick && !accept) begin
         tok_op = TOK_EARN;
      end else if (accept && !tick) begin
         tok_op = TOK_SPEND;
      end
      case (tok_op)
         TOK_EARN:  if (tokens != TOK_FULL) tokens_next = tokens + TOK_ONE;
         TOK_SPEND: tokens_next = tokens - TOK_ONE;
         default:   tokens_next = tokens;
      endcase
   end

   // Token bank register.
   always_ff @(posedge clock) begin
      if (reset == RST_ACTIVE) begin
         tokens <= '0;
      end else begin
         tokens <= tokens_next;
      end
   end

   axis_pipe_reg #(
      .WIDTH (WIDTH)
   ) u_pipe (
      .clock  (clock),
      .reset  (reset),
      .enable (have_token),
      .idata  (idata),
      .ivalid (ivalid),
      .iready (iready),
      .odata  (odata),
      .ovalid (ovalid),
      .oready (oready),
      .accept (accept)
   );

`ifdef AXIS_RATE_LIMITER_STATS_EN
   logic [31:0] stall_q;

   // Count cycles where the source is waiting only because the bucket is empty.
   always_ff @(posedge clock) begin
      if (reset == RST_ACTIVE) begin
         stall_q <= '0;
      end else if (ivalid && !have_token) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_count = stall_q;
`else
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_axis_rate_limiter.sv
// Bench for axis_rate_limiter: two instances (BURST=1 and BURST=3, period 4)
// share stimulus and are compared against a cycle-level token-bucket model.
module tb_axis_rate_limiter;

`ifdef AXIS_RATE_LIMITER_STATS_EN
   localparam bit STATS_ON = 1'b1;
`else
   localparam bit STATS_ON = 1'b0;
`endif

   logic        clock;
   logic        reset;
   logic [31:0] period;
   logic        period_load;
   logic [7:0]  idata;
   logic        ivalid;
   logic        oready;

   logic        iready_a, ovalid_a, iready_b, ovalid_b;
   logic [7:0]  odata_a, odata_b;
   logic [0:0]  tokens_a;
   logic [1:0]  tokens_b;
   logic [31:0] stall_a, stall_b;

   int checks   = 0;
   int failures = 0;

   axis_rate_limiter #(.WIDTH(8), .PERIOD_WIDTH(32), .DEFAULT_PERIOD(4), .BURST(1)) dut_a (
      .clock(clock), .reset(reset), .period(period), .period_load(period_load),
      .idata(idata), .ivalid(ivalid), .iready(iready_a), .odata(odata_a),
      .ovalid(ovalid_a), .oready(oready), .tokens(tokens_a), .stall_count(stall_a));

   axis_rate_limiter #(.WIDTH(8), .PERIOD_WIDTH(32), .DEFAULT_PERIOD(4), .BURST(3)) dut_b (
      .clock(clock), .reset(reset), .period(period), .period_load(period_load),
      .idata(idata), .ivalid(ivalid), .iready(iready_b), .odata(odata_b),
      .ovalid(ovalid_b), .oready(oready), .tokens(tokens_b), .stall_count(stall_b));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // DUT views indexed by unit (0 = BURST 1, 1 = BURST 3)
   logic        d_ir  [2];
   logic        d_ov  [2];
   logic [7:0]  d_od  [2];
   logic [31:0] d_tok [2];
   logic [31:0] d_st  [2];
   assign d_ir[0] = iready_a;  assign d_ir[1] = iready_b;
   assign d_ov[0] = ovalid_a;  assign d_ov[1] = ovalid_b;
   assign d_od[0] = odata_a;   assign d_od[1] = odata_b;
   assign d_tok[0] = 32'(tokens_a); assign d_tok[1] = 32'(tokens_b);
   assign d_st[0] = stall_a;   assign d_st[1] = stall_b;

   // Reference model: tick times are scheduled as absolute cycle numbers.
   int mburst [2] = '{1, 3};
   int m_tok  [2];
   int m_ov   [2];
   int m_od   [2];
   int m_per  [2];
   int m_next [2];
   int m_st   [2];
   int cyc = 0;

   function automatic bit m_ir(int u);
      return (m_tok[u] != 0) && (m_ov[u] == 0 || oready);
   endfunction

   task automatic model_adv();
      for (int u = 0; u < 2; u++) begin
         bit acc;
         bit tk;
         int eff;
         if (reset) begin
            m_tok[u] = 0; m_ov[u] = 0; m_od[u] = 0; m_st[u] = 0;
            m_per[u] = 4; m_next[u] = cyc + 4;
         end else begin
            acc = ivalid && m_ir(u);
            if (STATS_ON && ivalid && m_tok[u] == 0) m_st[u] = m_st[u] + 1;
            tk = !period_load && (cyc == m_next[u]);
            if (period_load) begin
               m_per[u] = int'(period);
               eff = (period == 0) ? 1 : int'(period);
               m_next[u] = cyc + eff;
            end else if (tk) begin
               eff = (m_per[u] == 0) ? 1 : m_per[u];
               m_next[u] = cyc + eff;
            end
            if (tk && !acc) begin
               if (m_tok[u] < mburst[u]) m_tok[u] = m_tok[u] + 1;
            end else if (acc && !tk) begin
               m_tok[u] = m_tok[u] - 1;
            end
            if (acc) begin
               m_ov[u] = 1; m_od[u] = int'(idata);
            end else if (m_ov[u] != 0 && oready) begin
               m_ov[u] = 0;
            end
         end
      end
      cyc = cyc + 1;
   endtask

   // Advance one clock with the inputs currently driven; returns 1 ns after the edge.
   task automatic step();
      model_adv();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; period_load = 1'b0; ivalid = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      oready = 1'b1; ivalid = 1'b1; idata = 8'hA5;
      reset = 1'b1; period_load = 1'b0; period = 32'd0;
      step();
      step();
      reset = 1'b0; ivalid = 1'b0;
      #1;
      checks++; if (ovalid_a !== 1'b0) begin failures++; $display("FAIL reset_ovalid got=%b want=0", ovalid_a); end
      checks++; if (odata_a !== 8'h00) begin failures++; $display("FAIL reset_odata got=%h want=00", odata_a); end
      checks++; if (tokens_b !== 2'd0) begin failures++; $display("FAIL reset_tokens got=%0d want=0", tokens_b); end
      checks++; if (iready_a !== 1'b0) begin failures++; $display("FAIL reset_iready got=%b want=0", iready_a); end
      checks++; if (stall_b !== 32'd0) begin failures++; $display("FAIL reset_stall got=%0d want=0", stall_b); end
   endtask

   task automatic test_throttle();
      int first;
      int nready;
      first = -1; nready = 0;
      do_reset();
      ivalid = 1'b1; oready = 1'b1;
      for (int i = 0; i < 24; i++) begin
         idata = 8'($urandom);
         #1;
         if (iready_a === 1'b1) begin
            nready++;
            if (first < 0) first = i;
         end
         checks++; if (iready_a !== m_ir(0)) begin failures++; $display("FAIL throttle_iready cyc=%0d got=%b want=%b", i, iready_a, m_ir(0)); end
         checks++; if (odata_a !== 8'(m_od[0])) begin failures++; $display("FAIL throttle_odata cyc=%0d got=%h want=%h", i, odata_a, 8'(m_od[0])); end
         step();
      end
      checks++; if (first != 4) begin failures++; $display("FAIL throttle_first_ready got=%0d want=4", first); end
      checks++; if (nready != 5) begin failures++; $display("FAIL throttle_ready_count got=%0d want=5", nready); end
   endtask

   task automatic test_burst();
      logic [15:0] mask;
      mask = '0;
      do_reset();
      ivalid = 1'b0; oready = 1'b1;
      for (int i = 0; i < 20; i++) step();
      checks++; if (tokens_b !== 2'd3) begin failures++; $display("FAIL burst_saturate got=%0d want=3", tokens_b); end
      checks++; if (tokens_a !== 1'b1) begin failures++; $display("FAIL burst1_saturate got=%0d want=1", tokens_a); end
      ivalid = 1'b1;
      for (int j = 0; j < 16; j++) begin
         idata = 8'($urandom);
         #1;
         mask[j] = iready_b;
         checks++; if (tokens_b !== 2'(m_tok[1])) begin failures++; $display("FAIL burst_tokens cyc=%0d got=%0d want=%0d", j, tokens_b, m_tok[1]); end
         step();
      end
      checks++; if (mask !== 16'b0001_0001_0001_0111) begin failures++; $display("FAIL burst_pattern got=%b want=0001000100010111", mask); end
   endtask

   task automatic test_backpressure();
      do_reset();
      ivalid = 1'b1; oready = 1'b0; idata = 8'h3C;
      for (int i = 0; i < 5; i++) step();
      for (int i = 0; i < 12; i++) begin
         ivalid = 1'($urandom); idata = 8'($urandom);
         #1;
         checks++; if (ovalid_a !== 1'b1) begin failures++; $display("FAIL bp_ovalid cyc=%0d got=%b want=1", i, ovalid_a); end
         checks++; if (odata_a !== 8'h3C) begin failures++; $display("FAIL bp_odata cyc=%0d got=%h want=3c", i, odata_a); end
         checks++; if (iready_b !== 1'b0) begin failures++; $display("FAIL bp_iready cyc=%0d got=%b want=0", i, iready_b); end
         step();
      end
      checks++; if (tokens_b !== 2'd3) begin failures++; $display("FAIL bp_tokens_b got=%0d want=3", tokens_b); end
      checks++; if (tokens_a !== 1'b1) begin failures++; $display("FAIL bp_tokens_a got=%0d want=1", tokens_a); end
   endtask

   task automatic test_period_load();
      int acc;
      do_reset();
      ivalid = 1'b1; oready = 1'b1;
      step(); step();
      period = 32'd0; period_load = 1'b1;
      step();
      period_load = 1'b0;
      step();
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         idata = 8'($urandom);
         #1;
         if (iready_a === 1'b1) acc++;
         checks++; if (odata_a !== 8'(m_od[0])) begin failures++; $display("FAIL p0_odata cyc=%0d got=%h want=%h", i, odata_a, 8'(m_od[0])); end
         step();
      end
      checks++; if (acc != 20) begin failures++; $display("FAIL p0_throughput got=%0d want=20", acc); end
      period = 32'd2; period_load = 1'b1;
      step();
      period_load = 1'b0;
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         idata = 8'($urandom);
         #1;
         if (iready_a === 1'b1) acc++;
         checks++; if (iready_b !== m_ir(1)) begin failures++; $display("FAIL p2_iready cyc=%0d got=%b want=%b", i, iready_b, m_ir(1)); end
         step();
      end
      checks++; if (acc != 9) begin failures++; $display("FAIL p2_throughput got=%0d want=9", acc); end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      ivalid = 1'b0; oready = 1'b0;
      for (int i = 0; i < 20; i++) step();
      ivalid = 1'b1; idata = 8'h5A;
      step();
      ivalid = 1'b0;
      #1;
      checks++; if (tokens_b !== 2'd2 || ovalid_b !== 1'b1) begin failures++; $display("FAIL mid_setup tokens=%0d ovalid=%b want=2,1", tokens_b, ovalid_b); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      checks++; if (ovalid_b !== 1'b0) begin failures++; $display("FAIL mid_ovalid got=%b want=0", ovalid_b); end
      checks++; if (tokens_b !== 2'd0) begin failures++; $display("FAIL mid_tokens got=%0d want=0", tokens_b); end
      checks++; if (odata_b !== 8'h00) begin failures++; $display("FAIL mid_odata got=%h want=00", odata_b); end
      ivalid = 1'b1; oready = 1'b1;
      for (int j = 0; j < 6; j++) begin
         #1;
         checks++; if (iready_b !== (j == 4)) begin failures++; $display("FAIL mid_restart cyc=%0d got=%b want=%b", j, iready_b, (j == 4)); end
         step();
      end
   endtask

   task automatic test_stats();
      int want;
      want = STATS_ON ? 12 : 0;
      do_reset();
      ivalid = 1'b0; oready = 1'b1;
      step();
      ivalid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         idata = 8'($urandom);
         step();
      end
      ivalid = 1'b0;
      #1;
      checks++; if (stall_a !== 32'(want)) begin failures++; $display("FAIL stats_a got=%0d want=%0d", stall_a, want); end
      checks++; if (stall_b !== 32'(want)) begin failures++; $display("FAIL stats_b got=%0d want=%0d", stall_b, want); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         reset       = ($urandom_range(0, 199) == 0);
         period_load = ($urandom_range(0, 49) == 0);
         period      = 32'($urandom_range(0, 6));
         ivalid      = 1'($urandom);
         oready      = ($urandom_range(0, 3) != 0);
         idata       = 8'($urandom);
         #1;
         for (int u = 0; u < 2; u++) begin
            checks++; if (d_ir[u] !== m_ir(u)) begin failures++; $display("FAIL rand_iready u=%0d cyc=%0d got=%b want=%b", u, i, d_ir[u], m_ir(u)); end
            checks++; if (d_ov[u] !== 1'(m_ov[u])) begin failures++; $display("FAIL rand_ovalid u=%0d cyc=%0d got=%b want=%0d", u, i, d_ov[u], m_ov[u]); end
            checks++; if (d_od[u] !== 8'(m_od[u])) begin failures++; $display("FAIL rand_odata u=%0d cyc=%0d got=%h want=%h", u, i, d_od[u], 8'(m_od[u])); end
            checks++; if (d_tok[u] !== 32'(m_tok[u])) begin failures++; $display("FAIL rand_tokens u=%0d cyc=%0d got=%0d want=%0d", u, i, d_tok[u], m_tok[u]); end
            checks++; if (d_st[u] !== 32'(m_st[u])) begin failures++; $display("FAIL rand_stall u=%0d cyc=%0d got=%0d want=%0d", u, i, d_st[u], m_st[u]); end
         end
         step();
      end
      reset = 1'b0; period_load = 1'b0;
   endtask

   initial begin
      reset = 1'b1; period = '0; period_load = 1'b0;
      idata = '0; ivalid = 1'b0; oready = 1'b1;
      @(negedge clock);
      test_reset();
      test_throttle();
      test_burst();
      test_backpressure();
      test_period_load();
      test_reset_midflight();
      test_stats();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
